sevenseg_scan_ctrl: RTL
=======================

# sevenseg_scan_ctrl

- Time-multiplexing scan controller for the board's 4-digit common-anode 7-segment display.
- Takes a 4-digit BCD value through a load/acknowledge handshake and holds it in a shadow register; a new value is applied only at a frame boundary, so a frame never mixes old and new digits.
- Steps the anodes at a programmable rate, with a blanking gap before each digit slot (anti-ghosting) and optional leading-zero suppression.
- Sits between the counter/datapath logic and the `an`/`cath`/`dp` pins.

## Interface
- PRESCALE, 50000: clock cycles per digit slot; legal range ≥ 4.
- BLANK, 16: cycles at the start of each slot with all anodes off; legal range 1 ≤ BLANK < PRESCALE.
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- load  in  1  one-cycle strobe: capture `value`.
- value  in  16  four BCD nibbles; [3:0] is digit0 (rightmost), [15:12] is digit3.
- lz_blank  in  1  1 = suppress leading zeros.
- dp_en  in  4  per-digit decimal-point enable; bit i belongs to digit i.
- load_ack  out  1  one-cycle pulse: staged value is now displayed.
- frame_tick  out  1  one-cycle pulse per completed 4-digit frame.
- an  out  4  anode enables, active low.
- cath  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low.

## Operation
- **State registers:**
  - `cnt`: 0..PRESCALE-1
  - `digit`: 0..3
  - `shown[15:0]`
  - `staging[15:0]`
  - `pending`
  - `load_ack`
  - `frame_tick`
- **Reset state:** all of the above are 0.
- **Slot counting:** `cnt` increments every cycle. At PRESCALE-1 it wraps to 0 and `digit` advances 0→1→2→3→0.
- **Frame boundary:** the cycle where `cnt`=PRESCALE-1 and `digit`=3.
- **Blank phase** (`cnt` < BLANK): an=1111, cath=1111111, dp=1.
- **Active phase:**
  - an = ~(1<<digit); nibble N = shown[4*digit+3 : 4*digit].
  - cath decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibbles 10..15 decode to 1111111.
  - dp = ~dp_en[digit].
- **Leading-zero suppression** (lz_blank=1):
  - Digit i (i ≥ 1) shows cath=1111111 when its nibble and every higher nibble are 0.
  - Digit0 is never suppressed.
  - `an` and `dp` are unaffected.
- **Load handshake:**
  - A load cycle writes `value` into `staging` and sets `pending`=1.
  - Further loads before the boundary overwrite `staging`; the latest value wins and only one ack is produced.
- **At the frame boundary, if `pending` or `load`:**
  - `shown` ← (load ? value : staging) and `pending` ← 0.
  - `load_ack`=1 in the next cycle, for 1 cycle.
  - A load that coincides with the boundary is applied in that same boundary.
- **frame_tick:** 1 in the cycle after every frame boundary, whether or not a value was applied.
- **Outputs:** `an`/`cath`/`dp` are combinational decodes of the registered `cnt`, `digit` and `shown`; there are no other pipeline stages.
- **Reset mid-operation:** any pending value is discarded, no ack is issued, and the display restarts blank at digit0 showing 0.

## Timing
- **Frame length:** 4×PRESCALE cycles; frame_tick period is the same.
- **Load latency:**
  - Load to `shown` update: 1 to 4×PRESCALE cycles.
  - Load to load_ack: one cycle after the first frame boundary at or after the load.
- **Slot alignment:** the new value first appears in the slot-0 active phase starting BLANK cycles after the boundary+1 cycle.
- **Reset release:** the first active phase begins at cycle BLANK after reset release (an=1110, cath=1000000).
- **Asynchronous reset:** assertion forces an=1111, cath=1111111, dp=1, load_ack=0, frame_tick=0 immediately, without waiting for a clock edge.

## Test plan
All scenarios use PRESCALE=8, BLANK=2.

1. **Reset and release:** reset low, then released.
   - During reset: an=1111, cath=1111111, dp=1, load_ack=0, frame_tick=0.
   - At cycles 2..7 after release: an=1110, cath=1000000.
2. **Scan order:** load value=0x1234, wait for ack.
   - Slots show an=1110/cath=0011001, an=1101/0110000, an=1011/0100100, an=0111/1111001 in that order.
   - frame_tick repeats every 32 cycles.
3. **Leading-zero suppression and invalid nibbles:**
   - value=0x0050, lz_blank=1: digits 3 and 2 give cath=1111111, digit1 gives 0010010, digit0 gives 1000000.
   - With lz_blank=0, digits 3 and 2 give 1000000.
   - value=0x00A0: digit1 gives 1111111.
4. **Tearing and latest-wins:**
   - Load 0x1111 while digit=1, then load 0x2222 while digit=2.
   - The display stays at the old value through digit3, then shows 2222.
   - Exactly one load_ack pulse, one cycle after the boundary.
5. **Load on the boundary:**
   - Load 0x9876 exactly on a frame-boundary cycle.
   - load_ack occurs the next cycle and the following slot0 shows 6 (0000010).
6. **Reset while pending, plus dp:**
   - Load, then pulse reset low before the boundary: load_ack is never asserted and shown=0.
   - dp_en=0100: dp=0 only during the digit2 active phase.

Source files
------------

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexing scan controller for a 4-digit common-anode 7-segment
// display. A BCD value is staged through a load/ack handshake and only
// applied at a frame boundary, so one frame never mixes old and new digits.
// Each digit slot opens with a blanking gap to suppress ghosting.
//
// Load handshake: `load` is a one-cycle strobe that captures `value` into the
// staging register; loads before the next frame boundary overwrite it (the
// latest value wins). At the boundary the staged value (or a load arriving
// in that same cycle) moves to the displayed register, and `load_ack` pulses
// high for exactly one cycle in the following cycle. There is no backpressure
// on `load`: it is always accepted.
module sevenseg_scan_ctrl #(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        lz_blank,
    input  logic [3:0]  dp_en,
    output logic        load_ack,
    output logic        frame_tick,
    output logic [3:0]  an,
    output logic [6:0]  cath,
    output logic        dp
);

    localparam int            CW        = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_MAX   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK);

    logic [CW-1:0] cnt;
    logic [1:0]    digit;
    logic [15:0]   shown;
    logic [15:0]   staging;
    logic          pending;

    logic          slot_end;
    logic          frame_boundary;
    logic          apply_value;

    logic [3:0]    nibble;
    logic          suppress;
    logic          blank_phase;
    logic [6:0]    seg;

    assign slot_end       = (cnt == CNT_MAX);
    assign frame_boundary = slot_end && (digit == 2'd3);
    assign apply_value    = frame_boundary && (pending || load);

    // Slot counter and digit pointer: the digit advances when a slot wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            digit <= 2'd0;
        end else if (slot_end) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    // Staging/shown registers: a load arriving on the boundary bypasses staging.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shown   <= '0;
            staging <= '0;
            pending <= 1'b0;
        end else begin
            if (load) begin
                staging <= value;
            end
            if (apply_value) begin
                shown   <= load ? value : staging;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // One-cycle status pulses, both following the boundary cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            load_ack   <= apply_value;
            frame_tick <= frame_boundary;
        end
    end

    // Leading-zero test: digit i is blanked when it and all higher nibbles are 0.
    always_comb begin
        nibble   = shown[{digit, 2'b00} +: 4];
        suppress = 1'b0;
        case (digit)
            2'd3:    suppress = (shown[15:12] == 4'h0);
            2'd2:    suppress = (shown[15:8]  == 8'h00);
            2'd1:    suppress = (shown[15:4]  == 12'h000);
            default: suppress = 1'b0;
        endcase
        suppress = suppress && lz_blank;
    end

    // BCD to active-low segments {g,f,e,d,c,b,a}; non-BCD nibbles stay dark.
    always_comb begin
        seg = 7'b1111111;
        case (nibble)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

    // Pin drive: everything off during the blanking gap at the start of a slot.
    always_comb begin
        blank_phase = (cnt < BLANK_END);
        an          = 4'b1111;
        cath        = 7'b1111111;
        dp          = 1'b1;
        if (!blank_phase) begin
            an   = ~(4'b0001 << digit);
            cath = suppress ? 7'b1111111 : seg;
            dp   = ~dp_en[digit];
        end
    end

endmodule
